stack_param: RTL and testbench
==============================

STACK_PARAM -- requirements
Module: stack_param

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 5, number of stack entries (2..256, need not be a power of two).
REQ-003 Derived localparam AW = $clog2(DEPTH), width of the pointer and INDEX; CW = $clog2(DEPTH+1), width of COUNT.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RESET_N  input  1  reset, asynchronous and active-low.
REQ-006 COMMAND  input  2  operation code: 00 nop, 01 push, 10 pop, 11 get.
REQ-007 CMD_VALID  input  1  qualifies COMMAND; when low the cycle is treated as nop.
REQ-008 IN_DATA  input  WIDTH  push operand.
REQ-009 INDEX  input  AW  get offset; 0 = top of stack.
REQ-010 OUT_DATA  output  WIDTH  registered pop/get result.
REQ-011 OUT_VALID  output  1  one-cycle pulse marking OUT_DATA valid.
REQ-012 ERROR  output  1  one-cycle pulse marking a rejected command.
REQ-013 COUNT  output  CW  number of occupied entries (0..DEPTH).
REQ-014 FULL / EMPTY  output  1 each  COUNT==DEPTH / COUNT==0, combinational from COUNT.

Function
REQ-015 Storage is a circular buffer of DEPTH words with top pointer HEAD (next free slot); all pointer arithmetic wraps modulo DEPTH, including the non-power-of-two case.
REQ-016 Every accepted command completes in one cycle; OUT_DATA, OUT_VALID and ERROR update on the rising edge following the command cycle (latency 1).
REQ-017 Push (not full): mem[HEAD]<=IN_DATA, HEAD<=HEAD+1 mod DEPTH, COUNT+1; OUT_VALID=0.
REQ-018 Pop (not empty): HEAD<=HEAD-1 mod DEPTH, COUNT-1, OUT_DATA<=mem[HEAD-1], OUT_VALID=1.
REQ-019 Get (INDEX<COUNT): OUT_DATA<=mem[(HEAD-1-INDEX) mod DEPTH], OUT_VALID=1, stack unchanged.
REQ-020 Pop on empty: no state change, OUT_VALID=0, ERROR=1.
REQ-021 Get with INDEX>=COUNT: no state change, OUT_VALID=0, ERROR=1.
REQ-022 Push on full: behaviour set by REQ-029/REQ-030.
REQ-023 Nop, or CMD_VALID=0: no state change, OUT_VALID=0, ERROR=0; OUT_DATA holds its last value.
REQ-024 OUT_VALID and ERROR are never high in the same cycle.

Reset
REQ-025 RESET_N low immediately forces HEAD=0, COUNT=0, OUT_DATA=0, OUT_VALID=0, ERROR=0 (EMPTY=1, FULL=0), without waiting for CLK.
REQ-026 Memory contents need not be cleared; no pop or get can return pre-reset data after reset.
REQ-027 A command presented in the cycle reset deasserts is ignored; commands are accepted from the first rising edge with RESET_N high.
REQ-028 Reset asserted mid-operation aborts that operation; no partial pointer or count update survives.

Configuration
REQ-029 With STACK_PARAM_WRAP_EN defined, push on full writes mem[HEAD], advances HEAD, keeps COUNT=DEPTH, overwrites the oldest entry, and leaves ERROR=0.
REQ-030 Without STACK_PARAM_WRAP_EN, push on full is rejected: no state change, ERROR=1.

Structure
REQ-031 Package stack_pkg holds the cmd_t enum (CMD_NOP, CMD_PUSH, CMD_POP, CMD_GET) and modulo-DEPTH increment/decrement helper functions.
REQ-032 Storage is a sub-module stack_param_mem with one write port and one combinational read port, parametrised by WIDTH and DEPTH; control logic, pointers and flags stay in stack_param.

Verification (WIDTH=4, DEPTH=5)
REQ-033 Push 1,2,3, then pop x3: OUT_DATA is 3, 2, 1, each with an OUT_VALID pulse one cycle after its pop; COUNT ends at 0 and EMPTY=1.
REQ-034 Push 4,5,6,7,8 so HEAD wraps to 0, then get INDEX 0..4: OUT_DATA is 8,7,6,5,4; get INDEX=5 gives ERROR=1.
REQ-035 With the stack full, push 9:
  - WRAP_EN build: no error, COUNT=5, pops return 9,8,7,6,5.
  - Non-wrap build: ERROR=1, COUNT=5, top remains 8.
REQ-036 From reset, pop gives ERROR=1; get INDEX=0 gives ERROR=1; COUNT stays 0.
REQ-037 Push 1,2, then assert RESET_N low between clock edges: COUNT=0, OUT_VALID=0 and EMPTY=1 immediately; after release, pop gives ERROR=1.
REQ-038 Hold COMMAND=01 with CMD_VALID=0 for 3 cycles: COUNT stays unchanged and no OUT_VALID or ERROR pulse occurs.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: command encoding and modulo-DEPTH pointer helpers for stack_param
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_t;

    // (p + 1) mod d for p < d, without a divider
    function automatic int unsigned inc_mod(input int unsigned p, input int unsigned d);
        return (p + 1 >= d) ? 0 : p + 1;
    endfunction

    // (p - k) mod d for p < d and k <= d, without a divider
    function automatic int unsigned sub_mod(input int unsigned p, input int unsigned k,
                                            input int unsigned d);
        int unsigned s;
        s = p + d - k;
        return (s >= d) ? s - d : s;
    endfunction

    // (p - 1) mod d for p < d
    function automatic int unsigned dec_mod(input int unsigned p, input int unsigned d);
        return sub_mod(p, 1, d);
    endfunction

endpackage

// File: rtl/stack_param_mem.sv
// stack_param_mem: DEPTH x WIDTH storage, one synchronous write port, one combinational read port
module stack_param_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // contents are never cleared; the control logic never reads unwritten slots
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_param.sv
// stack_param: LIFO stack on a circular buffer with push/pop/get; STACK_PARAM_WRAP_EN makes push-on-full overwrite the oldest entry
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [1:0]       COMMAND,
    input  logic             CMD_VALID,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [AW-1:0]    INDEX,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    output logic             ERROR,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY
);

`ifdef STACK_PARAM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    cmd_t             cmd;
    logic [AW-1:0]    head;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             push_ok;
    logic             pop_ok;
    logic             get_ok;
    logic             err;

    assign cmd   = CMD_VALID ? cmd_t'(COMMAND) : CMD_NOP;
    assign FULL  = COUNT == CW'(DEPTH);
    assign EMPTY = COUNT == '0;

    // decode which command is accepted and where the read port points (pop reads index 0)
    always_comb begin
        push_ok = cmd == CMD_PUSH && (!FULL || WRAP);
        pop_ok  = cmd == CMD_POP && !EMPTY;
        get_ok  = cmd == CMD_GET && 32'(INDEX) < 32'(COUNT);
        err     = (cmd == CMD_PUSH && !push_ok) || (cmd == CMD_POP && !pop_ok) ||
                  (cmd == CMD_GET && !get_ok);
        raddr   = AW'(sub_mod(32'(head), cmd == CMD_GET ? 32'(INDEX) + 1 : 1, DEPTH));
    end

    stack_param_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .CLK  (CLK),
        .we   (push_ok),
        .waddr(head),
        .wdata(IN_DATA),
        .raddr(raddr),
        .rdata(rdata)
    );

    // pointer, occupancy and registered result/status; a wrapping push keeps COUNT at DEPTH
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head      <= '0;
            COUNT     <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            if (push_ok) head <= AW'(inc_mod(32'(head), DEPTH));
            else if (pop_ok) head <= AW'(dec_mod(32'(head), DEPTH));
            if (push_ok && !FULL) COUNT <= COUNT + CW'(1);
            else if (pop_ok) COUNT <= COUNT - CW'(1);
            if (pop_ok || get_ok) OUT_DATA <= rdata;
            OUT_VALID <= pop_ok || get_ok;
            ERROR     <= err;
        end
    end

endmodule

// File: tb/tb_stack_param.sv
// tb_stack_param: directed self-checking bench for stack_param (WIDTH=4, DEPTH=5)
module tb_stack_param;

    logic       CLK;
    logic       RESET_N;
    logic [1:0] COMMAND;
    logic       CMD_VALID;
    logic [3:0] IN_DATA;
    logic [2:0] INDEX;
    logic [3:0] OUT_DATA;
    logic       OUT_VALID;
    logic       ERROR;
    logic [2:0] COUNT;
    logic       FULL;
    logic       EMPTY;

    int passed = 0;
    int total  = 0;

    stack_param #(.WIDTH(4), .DEPTH(5)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .COMMAND  (COMMAND),
        .CMD_VALID(CMD_VALID),
        .IN_DATA  (IN_DATA),
        .INDEX    (INDEX),
        .OUT_DATA (OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .ERROR    (ERROR),
        .COUNT    (COUNT),
        .FULL     (FULL),
        .EMPTY    (EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // present one command for one edge, sample 1 time unit after it, then fall back to nop
    task automatic do_cmd(input logic [1:0] c, input logic [3:0] d, input logic [2:0] i);
        COMMAND   = c;
        IN_DATA   = d;
        INDEX     = i;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        COMMAND   = 2'b00;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; CMD_VALID = 1'b0; COMMAND = 2'b00; IN_DATA = '0; INDEX = '0;
        #2;
        total++;
        if ({COUNT, EMPTY, FULL, OUT_VALID, ERROR, OUT_DATA} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0})
            $display("FAIL reset_state got cnt=%0d e=%b f=%b v=%b err=%b d=%0d want 0 1 0 0 0 0",
                     COUNT, EMPTY, FULL, OUT_VALID, ERROR, OUT_DATA);
        else passed++;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_empty_errors;
        do_cmd(2'b10, 4'd0, 3'd0);
        total++;
        if ({ERROR, OUT_VALID, COUNT} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL empty_pop got err=%b v=%b cnt=%0d want 1 0 0", ERROR, OUT_VALID, COUNT);
        else passed++;
        do_cmd(2'b11, 4'd0, 3'd0);
        total++;
        if ({ERROR, OUT_VALID, COUNT} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL empty_get got err=%b v=%b cnt=%0d want 1 0 0", ERROR, OUT_VALID, COUNT);
        else passed++;
    endtask

    task automatic test_push_pop;
        for (int k = 1; k <= 3; k++) begin
            do_cmd(2'b01, 4'(k), 3'd0);
            total++;
            if ({OUT_VALID, ERROR, COUNT} !== {1'b0, 1'b0, 3'(k)})
                $display("FAIL push_%0d got v=%b err=%b cnt=%0d want 0 0 %0d", k, OUT_VALID, ERROR, COUNT, k);
            else passed++;
        end
        for (int k = 0; k < 3; k++) begin
            do_cmd(2'b10, 4'd0, 3'd0);
            total++;
            if ({OUT_VALID, ERROR, OUT_DATA, COUNT} !== {1'b1, 1'b0, 4'(3 - k), 3'(2 - k)})
                $display("FAIL pop_%0d got v=%b err=%b d=%0d cnt=%0d want 1 0 %0d %0d",
                         k, OUT_VALID, ERROR, OUT_DATA, COUNT, 3 - k, 2 - k);
            else passed++;
        end
        total++;
        if ({EMPTY, FULL} !== 2'b10)
            $display("FAIL pop_empty_flag got e=%b f=%b want 1 0", EMPTY, FULL);
        else passed++;
    endtask

    task automatic test_wrap_get;
        for (int k = 0; k < 5; k++) begin
            do_cmd(2'b01, 4'(4 + k), 3'd0);
            total++;
            if ({ERROR, COUNT} !== {1'b0, 3'(k + 1)})
                $display("FAIL fill_%0d got err=%b cnt=%0d want 0 %0d", k, ERROR, COUNT, k + 1);
            else passed++;
        end
        total++;
        if ({FULL, EMPTY} !== 2'b10)
            $display("FAIL full_flag got f=%b e=%b want 1 0", FULL, EMPTY);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            do_cmd(2'b11, 4'd0, 3'(k));
            total++;
            if ({OUT_VALID, ERROR, OUT_DATA, COUNT} !== {1'b1, 1'b0, 4'(8 - k), 3'd5})
                $display("FAIL get_%0d got v=%b err=%b d=%0d cnt=%0d want 1 0 %0d 5",
                         k, OUT_VALID, ERROR, OUT_DATA, COUNT, 8 - k);
            else passed++;
        end
        do_cmd(2'b11, 4'd0, 3'd5);
        total++;
        if ({OUT_VALID, ERROR, COUNT} !== {1'b0, 1'b1, 3'd5})
            $display("FAIL get_out_of_range got v=%b err=%b cnt=%0d want 0 1 5", OUT_VALID, ERROR, COUNT);
        else passed++;
    endtask

    task automatic test_full_push;
        int first;
        do_cmd(2'b01, 4'd9, 3'd0);
`ifdef STACK_PARAM_WRAP_EN
        first = 9;
        total++;
        if ({ERROR, OUT_VALID, COUNT, FULL} !== {1'b0, 1'b0, 3'd5, 1'b1})
            $display("FAIL wrap_push got err=%b v=%b cnt=%0d f=%b want 0 0 5 1", ERROR, OUT_VALID, COUNT, FULL);
        else passed++;
`else
        first = 8;
        total++;
        if ({ERROR, OUT_VALID, COUNT, FULL} !== {1'b1, 1'b0, 3'd5, 1'b1})
            $display("FAIL full_push got err=%b v=%b cnt=%0d f=%b want 1 0 5 1", ERROR, OUT_VALID, COUNT, FULL);
        else passed++;
        do_cmd(2'b11, 4'd0, 3'd0);
        total++;
        if ({OUT_VALID, OUT_DATA} !== {1'b1, 4'd8})
            $display("FAIL full_top got v=%b d=%0d want 1 8", OUT_VALID, OUT_DATA);
        else passed++;
`endif
        for (int k = 0; k < 5; k++) begin
            do_cmd(2'b10, 4'd0, 3'd0);
            total++;
            if ({OUT_VALID, ERROR, OUT_DATA, COUNT} !== {1'b1, 1'b0, 4'(first - k), 3'(4 - k)})
                $display("FAIL drain_%0d got v=%b err=%b d=%0d cnt=%0d want 1 0 %0d %0d",
                         k, OUT_VALID, ERROR, OUT_DATA, COUNT, first - k, 4 - k);
            else passed++;
        end
    endtask

    task automatic test_cmd_valid;
        logic [3:0] hold;
`ifdef STACK_PARAM_WRAP_EN
        hold = 4'd5;
`else
        hold = 4'd4;
`endif
        COMMAND   = 2'b01;
        IN_DATA   = 4'hF;
        CMD_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            total++;
            if ({OUT_VALID, ERROR, COUNT, OUT_DATA} !== {1'b0, 1'b0, 3'd0, hold})
                $display("FAIL invalid_cmd_%0d got v=%b err=%b cnt=%0d d=%0d want 0 0 0 %0d",
                         k, OUT_VALID, ERROR, COUNT, OUT_DATA, hold);
            else passed++;
        end
        COMMAND = 2'b00;
    endtask

    task automatic test_async_reset;
        do_cmd(2'b01, 4'd1, 3'd0);
        do_cmd(2'b01, 4'd2, 3'd0);
        do_cmd(2'b11, 4'd0, 3'd0);
        total++;
        if ({OUT_VALID, OUT_DATA, COUNT} !== {1'b1, 4'd2, 3'd2})
            $display("FAIL pre_reset got v=%b d=%0d cnt=%0d want 1 2 2", OUT_VALID, OUT_DATA, COUNT);
        else passed++;
        #2;
        RESET_N = 1'b0;
        #1;
        total++;
        if ({COUNT, OUT_VALID, EMPTY, OUT_DATA} !== {3'd0, 1'b0, 1'b1, 4'd0})
            $display("FAIL async_reset got cnt=%0d v=%b e=%b d=%0d want 0 0 1 0", COUNT, OUT_VALID, EMPTY, OUT_DATA);
        else passed++;
        @(negedge CLK);
        RESET_N = 1'b1;
        do_cmd(2'b10, 4'd0, 3'd0);
        total++;
        if ({ERROR, OUT_VALID, COUNT} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL post_reset_pop got err=%b v=%b cnt=%0d want 1 0 0", ERROR, OUT_VALID, COUNT);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_empty_errors();
        test_push_pop();
        test_wrap_get();
        test_full_push();
        test_cmd_valid();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
